frng_ring_link_bridge: RTL and testbench
========================================

// Module: frng_ring_link_bridge
// PURPOSE
//  Parametrised successor to the single-bit wen ring node. Holds N_CH channel
//  registers of DATA_W bits. Channels are updated by remote "get" transfers, by
//  local writes and by the anchor loop (ch0 <= ch[N_CH-1]). Changed channels are
//  sent out as "put" transfers through a round-robin valid/ready port. Sits
//  between the fringe transport adapter and the per-simulation ring logic.
// PARAMETERS
//  N_CH          4   number of ring channels (>=2)
//  DATA_W        32  bits per channel
//  PUT_ON_CHANGE 1   1: mark pending only when value changes; 0: on every update
//  CNT_W         16  width of saturating statistic counters
//  IDX_W  $clog2(N_CH)  channel index width (derived, not overridden)
// PORTS
//  i_clk         in   1             clock; all logic rising-edge
//  reset         in   1             synchronous, active-high reset
//  i_get_valid   in   1             remote update valid
//  i_get_idx     in   IDX_W         remote channel index
//  i_get_data    in   DATA_W        remote channel value
//  i_loc_we      in   1             local write strobe
//  i_loc_idx     in   IDX_W         local channel index
//  i_loc_data    in   DATA_W        local value
//  i_anchor_en   in   1             enable ch0 <= ch[N_CH-1] every cycle
//  o_put_valid   out  1             put transfer valid
//  i_put_ready   in   1             transport accepts put
//  o_put_idx     out  IDX_W         channel being put
//  o_put_data    out  DATA_W        snapshot of channel value
//  o_chan        out  N_CH*DATA_W   all channel registers, ch0 in LSBs
//  o_pending     out  N_CH          per-channel put-pending flags
//  o_coalesce_cnt out CNT_W         updates merged into an already pending channel
//  o_err         out  1             sticky: get/local index >= N_CH
// BEHAVIOUR
//  - Reset: channels, o_pending, o_put_valid/idx/data, counters, o_err, rr ptr = 0.
//  - Update priority per channel, same cycle: get > local > anchor (ch0 only).
//    Losing sources are dropped; the drop counts as a coalesce event.
//  - Channel registers update on the edge after the strobe; o_chan is registered.
//  - Anchor reads ch[N_CH-1] pre-edge value (1-cycle ring delay).
//  - Out-of-range index: no channel write; o_err <= 1 until reset.
//  - Pending set: PUT_ON_CHANGE=1 -> new value != old; =0 -> any accepted update.
//    Pending set while already pending (not being cleared) -> coalesce_cnt++ (saturates).
//  - Put FSM: IDLE/SEND. IDLE: if any pending, select first pending at or after
//    rr ptr, latch idx + current data, o_put_valid<=1, go SEND (1 cycle latency).
//  - SEND: outputs held stable until i_put_ready. On handshake: clear that pending
//    bit (unless re-set the same cycle), rr ptr <= idx+1 mod N_CH; if another
//    pending remains, load it the same edge (back-to-back), else IDLE.
//  - A channel updated while in SEND keeps the old snapshot; pending is re-set,
//    so the new value is sent later.
//  - Reset during SEND: transfer abandoned, o_put_valid 0 next cycle.
// TESTING
//  1 reset, then get idx=2 data=0xA5 -> o_chan[2]=0xA5, pending=0100,
//    put idx=2 data=0xA5 valid two cycles after get.
//  2 ready low 5 cycles in SEND -> idx/data stable; ready high -> pending[2]=0, IDLE.
//  3 pending 1011, ready held 1 -> puts 0,1,3 on consecutive cycles,
//    then rr ptr=0.
//  4 anchor_en=1, write ch3=7 -> ch0=7 one cycle later; a get to ch0 in the
//    same cycle as the anchor wins, coalesce_cnt=1.
//  5 PUT_ON_CHANGE=1, rewrite same value -> no pending; PUT_ON_CHANGE=0 ->
//    pending set.
//  6 get idx=N_CH (N_CH not power of 2) -> o_err=1, no change; reset mid-SEND
//    -> all outputs 0.

Source files
------------

// File: rtl/frng_ring_link_bridge.sv
// Ring channel bridge: holds N_CH channel registers fed by remote gets, local writes and the
// anchor loop, and streams changed channels out as round-robin put transfers.
module frng_ring_link_bridge #(
   parameter int unsigned N_CH          = 4,
   parameter int unsigned DATA_W        = 32,
   parameter bit          PUT_ON_CHANGE = 1'b1,
   parameter int unsigned CNT_W         = 16,
   localparam int unsigned IDX_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                     i_clk,
   input  logic                     reset,
   input  logic                     i_get_valid,
   input  logic [IDX_W-1:0]         i_get_idx,
   input  logic [DATA_W-1:0]        i_get_data,
   input  logic                     i_loc_we,
   input  logic [IDX_W-1:0]         i_loc_idx,
   input  logic [DATA_W-1:0]        i_loc_data,
   input  logic                     i_anchor_en,
   output logic                     o_put_valid,
   input  logic                     i_put_ready,
   output logic [IDX_W-1:0]         o_put_idx,
   output logic [DATA_W-1:0]        o_put_data,
   output logic [N_CH*DATA_W-1:0]   o_chan,
   output logic [N_CH-1:0]          o_pending,
   output logic [CNT_W-1:0]         o_coalesce_cnt,
   output logic                     o_err
);

   localparam logic [IDX_W:0] NChX = (IDX_W + 1)'(N_CH);

   typedef enum logic {StIdle, StSend} state_e;

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   ch_q [N_CH];
   logic [DATA_W-1:0]   ch_d [N_CH];
   logic [N_CH-1:0]     pend_q, pend_d;
   logic [IDX_W-1:0]    put_idx_q, put_idx_d;
   logic [DATA_W-1:0]   put_data_q, put_data_d;
   logic [IDX_W-1:0]    rr_q, rr_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                err_q, err_d;

   logic                get_ok, loc_ok, hs;
   logic [N_CH-1:0]     get_sel, loc_sel, anc_sel, upd, changed, clr, reset_vec, rem;
   logic [IDX_W-1:0]    nxt_idx;
   int unsigned         coal_inc;
   logic [CNT_W:0]      cnt_sum;

   // First set bit of req at or after start, wrapping modulo N_CH.
   function automatic logic [IDX_W-1:0] pick(input logic [N_CH-1:0] req,
                                             input logic [IDX_W-1:0] start);
      logic        found;
      int unsigned j;
      pick  = start;
      found = 1'b0;
      for (int k = 0; k < N_CH; k++) begin
         j = (int'(start) + k) % N_CH;
         if (!found && req[j]) begin
            pick  = IDX_W'(j);
            found = 1'b1;
         end
      end
   endfunction

   assign get_ok  = i_get_valid && ({1'b0, i_get_idx} < NChX);
   assign loc_ok  = i_loc_we && ({1'b0, i_loc_idx} < NChX);
   assign hs      = (state_q == StSend) && i_put_ready;
   assign nxt_idx = (put_idx_q == IDX_W'(N_CH - 1)) ? '0 : put_idx_q + 1'b1;

   always_comb begin
      get_sel = '0;
      loc_sel = '0;
      anc_sel = '0;
      if (get_ok) get_sel[i_get_idx] = 1'b1;
      if (loc_ok) loc_sel[i_loc_idx] = 1'b1;
      anc_sel[0] = i_anchor_en;
   end

   // Channel updates with get > local > anchor priority.
   always_comb begin
      upd = '0;
      for (int c = 0; c < N_CH; c++) begin
         ch_d[c] = ch_q[c];
         if (get_sel[c]) begin
            ch_d[c] = i_get_data;
            upd[c]  = 1'b1;
         end else if (loc_sel[c]) begin
            ch_d[c] = i_loc_data;
            upd[c]  = 1'b1;
         end else if (anc_sel[c]) begin
            ch_d[c] = ch_q[N_CH-1];
            upd[c]  = 1'b1;
         end
      end
   end

   always_comb begin
      clr = '0;
      if (hs) clr[put_idx_q] = 1'b1;
      for (int c = 0; c < N_CH; c++) begin
         changed[c] = upd[c] && (!PUT_ON_CHANGE || (ch_d[c] != ch_q[c]));
      end
      pend_d    = changed | (pend_q & ~clr);
      reset_vec = changed & pend_q & ~clr;
   end

   // Coalesce events: each dropped source plus each re-set of a still-pending channel.
   always_comb begin
      coal_inc = $countones(reset_vec);
      if (|(get_sel & loc_sel)) coal_inc = coal_inc + 1;
      if (anc_sel[0] && (get_sel[0] || loc_sel[0])) coal_inc = coal_inc + 1;
      cnt_sum = {1'b0, cnt_q} + (CNT_W + 1)'(coal_inc);
      cnt_d   = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
      err_d   = err_q || (i_get_valid && !get_ok) || (i_loc_we && !loc_ok);
   end

   always_comb begin
      state_d    = state_q;
      put_idx_d  = put_idx_q;
      put_data_d = put_data_q;
      rr_d       = rr_q;
      rem        = pend_q & ~clr;
      case (state_q)
         StIdle: begin
            if (|pend_q) begin
               put_idx_d  = pick(pend_q, rr_q);
               put_data_d = ch_q[put_idx_d];
               state_d    = StSend;
            end
         end
         StSend: begin
            if (i_put_ready) begin
               rr_d = nxt_idx;
               if (|rem) begin
                  put_idx_d  = pick(rem, nxt_idx);
                  put_data_d = ch_q[put_idx_d];
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (reset) begin
         state_q    <= StIdle;
         pend_q     <= '0;
         put_idx_q  <= '0;
         put_data_q <= '0;
         rr_q       <= '0;
         cnt_q      <= '0;
         err_q      <= 1'b0;
         for (int c = 0; c < N_CH; c++) ch_q[c] <= '0;
      end else begin
         state_q    <= state_d;
         pend_q     <= pend_d;
         put_idx_q  <= put_idx_d;
         put_data_q <= put_data_d;
         rr_q       <= rr_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
         for (int c = 0; c < N_CH; c++) ch_q[c] <= ch_d[c];
      end
   end

   always_comb begin
      for (int c = 0; c < N_CH; c++) o_chan[c*DATA_W +: DATA_W] = ch_q[c];
   end

   assign o_put_valid    = (state_q == StSend);
   assign o_put_idx      = put_idx_q;
   assign o_put_data     = put_data_q;
   assign o_pending      = pend_q;
   assign o_coalesce_cnt = cnt_q;
   assign o_err          = err_q;

endmodule

// File: tb/tb_frng_ring_link_bridge.sv
// Bench for frng_ring_link_bridge: directed scenarios plus randomized traffic checked against a
// last-writer-wins behavioural model; a second small instance covers PUT_ON_CHANGE=0 and errors.
module tb_frng_ring_link_bridge;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   // Main instance: N_CH=4, DATA_W=32, PUT_ON_CHANGE=1
   logic        get_valid = 0, loc_we = 0, anchor_en = 0, put_ready = 0;
   logic [1:0]  get_idx = 0, loc_idx = 0;
   logic [31:0] get_data = 0, loc_data = 0;
   logic        put_valid, err;
   logic [1:0]  put_idx;
   logic [31:0] put_data;
   logic [127:0] chan;
   logic [3:0]  pending;
   logic [15:0] cnt;

   // Alternate instance: N_CH=3, DATA_W=8, PUT_ON_CHANGE=0
   logic        a_get_valid = 0, a_loc_we = 0, a_put_ready = 0;
   logic [1:0]  a_get_idx = 0, a_loc_idx = 0;
   logic [7:0]  a_get_data = 0, a_loc_data = 0;
   logic        a_put_valid, a_err;
   logic [1:0]  a_put_idx;
   logic [7:0]  a_put_data;
   logic [23:0] a_chan;
   logic [2:0]  a_pending;
   logic [3:0]  a_cnt;

   frng_ring_link_bridge #(.N_CH(4), .DATA_W(32), .PUT_ON_CHANGE(1'b1), .CNT_W(16)) dut (
      .i_clk(clk), .reset(reset),
      .i_get_valid(get_valid), .i_get_idx(get_idx), .i_get_data(get_data),
      .i_loc_we(loc_we), .i_loc_idx(loc_idx), .i_loc_data(loc_data),
      .i_anchor_en(anchor_en),
      .o_put_valid(put_valid), .i_put_ready(put_ready), .o_put_idx(put_idx),
      .o_put_data(put_data), .o_chan(chan), .o_pending(pending),
      .o_coalesce_cnt(cnt), .o_err(err)
   );

   frng_ring_link_bridge #(.N_CH(3), .DATA_W(8), .PUT_ON_CHANGE(1'b0), .CNT_W(4)) dut_alt (
      .i_clk(clk), .reset(reset),
      .i_get_valid(a_get_valid), .i_get_idx(a_get_idx), .i_get_data(a_get_data),
      .i_loc_we(a_loc_we), .i_loc_idx(a_loc_idx), .i_loc_data(a_loc_data),
      .i_anchor_en(1'b0),
      .o_put_valid(a_put_valid), .i_put_ready(a_put_ready), .o_put_idx(a_put_idx),
      .o_put_data(a_put_data), .o_chan(a_chan), .o_pending(a_pending),
      .o_coalesce_cnt(a_cnt), .o_err(a_err)
   );

   int total = 0;
   int bad = 0;

   // Behavioural model of the main instance
   logic [31:0] m_ch [4];
   logic [3:0]  m_pend;
   bit          m_busy;
   int          m_idx, m_rr, m_cnt;
   logic [31:0] m_data;

   function automatic logic [127:0] m_chan();
      logic [127:0] v;
      for (int c = 0; c < 4; c++) v[c*32 +: 32] = m_ch[c];
      return v;
   endfunction

   task automatic model_step();
      logic [31:0] nc [4];
      bit   wrote [4];
      logic [3:0] np;
      int   ev, old, j;
      bit   hs, set, clr, found;
      if (reset) begin
         for (int c = 0; c < 4; c++) m_ch[c] = '0;
         m_pend = '0; m_busy = 0; m_idx = 0; m_rr = 0; m_cnt = 0; m_data = '0;
         return;
      end
      nc = m_ch;
      for (int c = 0; c < 4; c++) wrote[c] = 0;
      ev = 0;
      // Apply sources lowest priority first; a later writer displaces an earlier one.
      if (anchor_en) begin nc[0] = m_ch[3]; wrote[0] = 1; end
      if (loc_we) begin
         if (wrote[loc_idx]) ev++;
         nc[loc_idx] = loc_data; wrote[loc_idx] = 1;
      end
      if (get_valid) begin
         if (wrote[get_idx]) ev++;
         nc[get_idx] = get_data; wrote[get_idx] = 1;
      end
      hs = m_busy && put_ready;
      for (int c = 0; c < 4; c++) begin
         set = wrote[c] && (nc[c] != m_ch[c]);
         clr = hs && (m_idx == c);
         if (set && m_pend[c] && !clr) ev++;
         np[c] = set || (m_pend[c] && !clr);
      end
      found = 0;
      if (!m_busy) begin
         for (int k = 0; k < 4; k++) begin
            j = (m_rr + k) % 4;
            if (!found && m_pend[j]) begin
               found = 1; m_busy = 1; m_idx = j; m_data = m_ch[j];
            end
         end
      end else if (hs) begin
         old = m_idx;
         m_rr = (old + 1) % 4;
         m_busy = 0;
         for (int k = 0; k < 4; k++) begin
            j = (m_rr + k) % 4;
            if (!found && m_pend[j] && j != old) begin
               found = 1; m_busy = 1; m_idx = j; m_data = m_ch[j];
            end
         end
      end
      m_cnt = (m_cnt + ev > 65535) ? 65535 : m_cnt + ev;
      m_ch = nc;
      m_pend = np;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      get_valid = 0; loc_we = 0; anchor_en = 0;
      a_get_valid = 0; a_loc_we = 0;
   endtask

   task automatic test_reset();
      reset = 1;
      tick(); tick();
      reset = 0;
      total++; if (chan !== 128'd0) begin bad++; $display("FAIL reset_chan got=%h want=0", chan); end
      total++; if (pending !== 4'd0) begin bad++; $display("FAIL reset_pending got=%b want=0", pending); end
      total++; if (put_valid !== 1'b0 || put_idx !== 2'd0 || put_data !== 32'd0) begin
         bad++; $display("FAIL reset_put got=%b/%0d/%h want=0/0/0", put_valid, put_idx, put_data);
      end
      total++; if (cnt !== 16'd0 || err !== 1'b0) begin
         bad++; $display("FAIL reset_cnt_err got=%0d/%b want=0/0", cnt, err);
      end
      total++; if (a_chan !== 24'd0 || a_pending !== 3'd0 || a_put_valid !== 1'b0 || a_err !== 1'b0) begin
         bad++; $display("FAIL reset_alt got=%h/%b/%b/%b want=0", a_chan, a_pending, a_put_valid, a_err);
      end
   endtask

   task automatic test_get();
      put_ready = 0;
      get_valid = 1; get_idx = 2; get_data = 32'hA5;
      tick();
      idle_inputs();
      total++; if (chan[95:64] !== 32'hA5) begin bad++; $display("FAIL get_chan2 got=%h want=a5", chan[95:64]); end
      total++; if (pending !== 4'b0100) begin bad++; $display("FAIL get_pending got=%b want=0100", pending); end
      total++; if (put_valid !== 1'b0) begin bad++; $display("FAIL get_early_valid got=%b want=0", put_valid); end
      tick();
      total++; if (put_valid !== 1'b1 || put_idx !== 2'd2 || put_data !== 32'hA5) begin
         bad++; $display("FAIL get_put got=%b/%0d/%h want=1/2/a5", put_valid, put_idx, put_data);
      end
   endtask

   task automatic test_stall();
      for (int i = 0; i < 5; i++) begin
         tick();
         total++; if (put_valid !== 1'b1 || put_idx !== 2'd2 || put_data !== 32'hA5) begin
            bad++; $display("FAIL stall_hold cyc=%0d got=%b/%0d/%h want=1/2/a5", i, put_valid, put_idx, put_data);
         end
      end
      put_ready = 1;
      tick();
      put_ready = 0;
      total++; if (pending !== 4'd0 || put_valid !== 1'b0) begin
         bad++; $display("FAIL stall_release got=%b/%b want=0000/0", pending, put_valid);
      end
   endtask

   task automatic test_back_to_back();
      logic [1:0]  exp_idx [3];
      logic [31:0] exp_dat [3];
      exp_idx[0] = 0; exp_idx[1] = 1; exp_idx[2] = 3;
      exp_dat[0] = 32'h11; exp_dat[1] = 32'h22; exp_dat[2] = 32'h13;
      put_ready = 0;
      get_valid = 1; get_idx = 0; get_data = 32'h11;
      loc_we = 1; loc_idx = 1; loc_data = 32'h22;
      tick();
      idle_inputs();
      get_valid = 1; get_idx = 3; get_data = 32'h13;
      tick();
      idle_inputs();
      total++; if (pending !== 4'b1011) begin bad++; $display("FAIL b2b_pending got=%b want=1011", pending); end
      put_ready = 1;
      for (int i = 0; i < 3; i++) begin
         total++; if (put_valid !== 1'b1 || put_idx !== exp_idx[i] || put_data !== exp_dat[i]) begin
            bad++; $display("FAIL b2b_put n=%0d got=%b/%0d/%h want=1/%0d/%h",
                            i, put_valid, put_idx, put_data, exp_idx[i], exp_dat[i]);
         end
         tick();
      end
      total++; if (put_valid !== 1'b0 || pending !== 4'd0) begin
         bad++; $display("FAIL b2b_drain got=%b/%b want=0/0000", put_valid, pending);
      end
      // Round-robin pointer must have wrapped to 0: ch0 wins over ch3.
      put_ready = 0;
      get_valid = 1; get_idx = 3; get_data = 32'h33;
      loc_we = 1; loc_idx = 0; loc_data = 32'h33;
      tick();
      idle_inputs();
      tick();
      total++; if (put_valid !== 1'b1 || put_idx !== 2'd0) begin
         bad++; $display("FAIL rr_wrap got=%b/%0d want=1/0", put_valid, put_idx);
      end
      put_ready = 1;
      tick(); tick();
   endtask

   task automatic test_anchor();
      anchor_en = 1;
      loc_we = 1; loc_idx = 3; loc_data = 32'd7;
      tick();
      loc_we = 0;
      total++; if (chan[31:0] !== 32'h33 || chan[127:96] !== 32'd7) begin
         bad++; $display("FAIL anchor_delay got=%h/%h want=33/7", chan[31:0], chan[127:96]);
      end
      tick();
      total++; if (chan[31:0] !== 32'd7) begin bad++; $display("FAIL anchor_copy got=%h want=7", chan[31:0]); end
      for (int i = 0; i < 4; i++) tick();
      get_valid = 1; get_idx = 0; get_data = 32'h55;
      tick();
      idle_inputs();
      total++; if (chan[31:0] !== 32'h55) begin bad++; $display("FAIL anchor_get_wins got=%h want=55", chan[31:0]); end
      total++; if (cnt !== 16'd1) begin bad++; $display("FAIL anchor_coalesce got=%0d want=1", cnt); end
      for (int i = 0; i < 3; i++) tick();
   endtask

   task automatic test_same_value();
      loc_we = 1; loc_idx = 1; loc_data = m_ch[1];
      tick();
      idle_inputs();
      total++; if (pending !== 4'd0 || put_valid !== 1'b0) begin
         bad++; $display("FAIL same_value_main got=%b/%b want=0000/0", pending, put_valid);
      end
      a_put_ready = 0;
      a_loc_we = 1; a_loc_idx = 1; a_loc_data = 8'd0;
      tick();
      idle_inputs();
      total++; if (a_pending !== 3'b010) begin bad++; $display("FAIL same_value_alt got=%b want=010", a_pending); end
      tick();
      total++; if (a_put_valid !== 1'b1 || a_put_idx !== 2'd1 || a_put_data !== 8'd0) begin
         bad++; $display("FAIL alt_put got=%b/%0d/%h want=1/1/00", a_put_valid, a_put_idx, a_put_data);
      end
      a_put_ready = 1;
      tick();
      total++; if (a_pending !== 3'd0 || a_put_valid !== 1'b0) begin
         bad++; $display("FAIL alt_drain got=%b/%b want=000/0", a_pending, a_put_valid);
      end
   endtask

   task automatic test_err_and_reset();
      a_get_valid = 1; a_get_idx = 2'd3; a_get_data = 8'hFF;
      tick();
      idle_inputs();
      total++; if (a_err !== 1'b1 || a_chan !== 24'd0 || a_pending !== 3'd0) begin
         bad++; $display("FAIL err_set got=%b/%h/%b want=1/0/000", a_err, a_chan, a_pending);
      end
      tick(); tick();
      total++; if (a_err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b want=1", a_err); end
      put_ready = 0;
      get_valid = 1; get_idx = 1; get_data = 32'hDEAD0001;
      tick();
      idle_inputs();
      tick();
      total++; if (put_valid !== 1'b1 || put_idx !== 2'd1) begin
         bad++; $display("FAIL send_before_reset got=%b/%0d want=1/1", put_valid, put_idx);
      end
      reset = 1;
      tick();
      reset = 0;
      total++; if (put_valid !== 0 || put_idx !== 0 || put_data !== 0 || pending !== 0 || chan !== 0
                   || cnt !== 0 || err !== 0) begin
         bad++; $display("FAIL reset_mid_send got=%b/%0d/%h/%b/%h/%0d/%b want=all 0",
                         put_valid, put_idx, put_data, pending, chan, cnt, err);
      end
      total++; if (a_err !== 1'b0) begin bad++; $display("FAIL err_cleared got=%b want=0", a_err); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         get_valid = 1'($urandom_range(0, 1));
         get_idx   = 2'($urandom_range(0, 3));
         get_data  = 32'($urandom_range(0, 3));
         loc_we    = 1'($urandom_range(0, 1));
         loc_idx   = 2'($urandom_range(0, 3));
         loc_data  = 32'($urandom_range(0, 3));
         anchor_en = ($urandom_range(0, 3) == 0);
         put_ready = 1'($urandom_range(0, 1));
         reset     = ($urandom_range(0, 99) == 0);
         tick();
         total++;
         if (chan !== m_chan() || pending !== m_pend || put_valid !== m_busy || cnt !== 16'(m_cnt)
             || err !== 1'b0 || (m_busy && (put_idx !== 2'(m_idx) || put_data !== m_data))) begin
            bad++;
            $display("FAIL random cyc=%0d got=%h/%b/%b/%0d/%h/%0d want=%h/%b/%b/%0d/%h/%0d", i, chan,
                     pending, put_valid, put_idx, put_data, cnt, m_chan(), m_pend, m_busy, m_idx,
                     m_data, m_cnt);
         end
      end
      reset = 0;
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_get();
      test_stall();
      test_back_to_back();
      test_anchor();
      test_same_value();
      test_err_and_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
